// File: rtl/tfcall_accum.sv
// rtl/tfcall_accum.sv - multi-channel accumulator with command interface and READ result FIFO
//
// Purpose:
//   Holds CHANNELS independent WIDTH-bit accumulators. Each accepted command
//   runs in a single cycle:
//     ADD  : acc += data (wraps; carry-out sets the sticky overflow flag)
//     DBL  : acc  = data << 1 (the shifted-out MSB sets the sticky overflow flag)
//     CLR  : acc  = 0, overflow flag cleared
//     READ : pushes {ch, acc} into a DEPTH-entry output FIFO
//   A command aimed at a channel that does not exist is still accepted, has no
//   effect, and pulses err on the following cycle.
//
// Build option:
//   TFCALL_ACCUM_SAT_EN - when defined, an overflowing ADD or DBL clamps the
//   accumulator to all-ones instead of wrapping. The overflow flag is set either way.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         command handshake (in_ready = FIFO not full)
//   in_op, in_ch, in_data     opcode (0 ADD, 1 DBL, 2 CLR, 3 READ), channel, operand
//   out_valid/out_ready       FIFO head handshake
//   out_ch, out_data          FIFO head entry
//   overflow                  sticky per-channel overflow flags
//   err                       one-cycle pulse for a command to an invalid channel
//   count                     FIFO occupancy

module tfcall_accum #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    parameter  int DEPTH    = 4,
    localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [CHW-1:0]      in_ch,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CHW-1:0]      out_ch,
    output logic [WIDTH-1:0]    out_data,
    output logic [CHANNELS-1:0] overflow,
    output logic                err,
    output logic [CW-1:0]       count
);

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_DBL = 2'd1;
    localparam logic [1:0] OP_CLR = 2'd2;
    localparam logic [1:0] OP_RD  = 2'd3;

    logic [WIDTH-1:0]     r_acc [CHANNELS];
    logic [CHANNELS-1:0]  r_ovf;
    logic [CHW+WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr;
    logic [AW-1:0]        r_rd;
    logic [CW-1:0]        r_count;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_ch_ok;
    logic [31:0]          w_ch_ext;
    logic [WIDTH-1:0]     w_cur;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH-1:0]     w_new;
    logic                 w_ovf;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_nonempty;

    // in_ready depends only on registered occupancy, never on out_ready, so a
    // full FIFO refuses commands until a pop has actually taken place.
    assign w_nonempty = (r_count != '0);
    assign in_ready   = (r_count != CW'(DEPTH));
    assign w_accept   = in_valid && in_ready;

    // Widen before comparing so the check stays meaningful when CHANNELS is
    // not a power of two (e.g. channel 3 of a 3-channel build).
    assign w_ch_ext = 32'(in_ch);
    assign w_ch_ok  = (w_ch_ext < 32'(CHANNELS));

    // Only consumed when w_ch_ok, so an out-of-range read here is harmless.
    assign w_cur = r_acc[in_ch];
    assign w_sum = {1'b0, w_cur} + {1'b0, in_data};

    always_comb begin
        w_new = w_cur;
        w_ovf = 1'b0;
        case (in_op)
            OP_ADD: begin
                w_new = w_sum[WIDTH-1:0];
                w_ovf = w_sum[WIDTH];
            end
            OP_DBL: begin
                w_new = {in_data[WIDTH-2:0], 1'b0};
                w_ovf = in_data[WIDTH-1];
            end
            default: begin
                w_new = w_cur;
                w_ovf = 1'b0;
            end
        endcase
`ifdef TFCALL_ACCUM_SAT_EN
        if (w_ovf) begin
            w_new = '1;
        end
`endif
    end

    assign w_push = w_accept && w_ch_ok && (in_op == OP_RD);
    assign w_pop  = w_nonempty && out_ready;

    // Accumulators and sticky overflow flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
            end
            r_ovf <= '0;
        end else if (w_accept && w_ch_ok) begin
            case (in_op)
                OP_ADD, OP_DBL: begin
                    r_acc[in_ch] <= w_new;
                    if (w_ovf) begin
                        r_ovf[in_ch] <= 1'b1;
                    end
                end
                OP_CLR: begin
                    r_acc[in_ch] <= '0;
                    r_ovf[in_ch] <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_ch_ok;
        end
    end

    // FIFO storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= {in_ch, w_cur};
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid = w_nonempty;
    assign out_ch    = w_nonempty ? r_mem[r_rd][CHW+WIDTH-1:WIDTH] : '0;
    assign out_data  = w_nonempty ? r_mem[r_rd][WIDTH-1:0]         : '0;
    assign overflow  = r_ovf;
    assign err       = r_err;
    assign count     = r_count;

endmodule

// File: tb/tb_tfcall_accum.sv
// tb/tb_tfcall_accum.sv - scoreboard testbench for tfcall_accum (WIDTH=8, CHANNELS=3, DEPTH=4)

module tb_tfcall_accum;

    localparam int W   = 8;
    localparam int CH  = 3;
    localparam int D   = 4;
    localparam int CHW = 2;
    localparam int CW  = 3;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_DBL = 2'd1;
    localparam logic [1:0] OP_CLR = 2'd2;
    localparam logic [1:0] OP_RD  = 2'd3;

`ifdef TFCALL_ACCUM_SAT_EN
    localparam logic [7:0] E_ADD_OVF = 8'd255;
    localparam logic [7:0] E_DBL_OVF = 8'hFF;
`else
    localparam logic [7:0] E_ADD_OVF = 8'd44;
    localparam logic [7:0] E_DBL_OVF = 8'h20;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [1:0]     in_op = 2'd0;
    logic [CHW-1:0] in_ch = '0;
    logic [W-1:0]   in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [CHW-1:0] out_ch;
    logic [W-1:0]   out_data;
    logic [CH-1:0]  overflow;
    logic           err;
    logic [CW-1:0]  count;

    int n_pass  = 0;
    int n_total = 0;
    int w;
    int w5;
    logic [CHW+W-1:0] exp_q[$];

    tfcall_accum #(.WIDTH(W), .CHANNELS(CH), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .overflow  (overflow),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Monitor: every pop the DUT performs is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_out: got ch %0d data %0h required no output", out_ch, out_data);
            end else begin
                logic [CHW+W-1:0] e;
                e = exp_q.pop_front();
                check("out_ch", 32'(out_ch), 32'(e[W +: CHW]));
                check("out_data", 32'(out_data), 32'(e[W-1:0]));
            end
        end
    end

    // Issue one command and return once it has been accepted (posedge + 1).
    task automatic cmd(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] d, output int waited);
        in_op    = op;
        in_ch    = ch;
        in_data  = d;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL cmd_timeout: got in_ready 0 required 1");
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] ch, input logic [7:0] exp_data, output int waited);
        exp_q.push_back({ch, exp_data});
        cmd(OP_RD, ch, 8'h00, waited);
    endtask

    task automatic wait_drain();
        int k = 0;
        while ((count != 0 || exp_q.size() != 0) && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state while rst is held, between clock edges.
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        @(negedge clk);
        rst = 1'b0;

        // ADD 1, ADD 2, READ -> 3 one cycle after the READ.
        cmd(OP_ADD, 2'd0, 8'd1, w);
        check("first_accept_wait", 32'(w), 32'd0);
        check("err_valid_ch", 32'(err), 32'd0);
        cmd(OP_ADD, 2'd0, 8'd2, w);
        rd(2'd0, 8'd3, w);
        check("read_latency_valid", 32'(out_valid), 32'd1);
        check("read_latency_data", 32'(out_data), 32'd3);
        check("ovf0_clear", 32'(overflow[0]), 32'd0);
        wait_drain();

        // ADD 200 + 100 wraps (or saturates) and flags overflow.
        cmd(OP_ADD, 2'd1, 8'd200, w);
        cmd(OP_ADD, 2'd1, 8'd100, w);
        rd(2'd1, E_ADD_OVF, w);
        check("ovf1_set", 32'(overflow[1]), 32'd1);
        wait_drain();

        // DBL with MSB set, then a clean DBL; flag stays sticky until CLR.
        cmd(OP_DBL, 2'd2, 8'h90, w);
        rd(2'd2, E_DBL_OVF, w);
        cmd(OP_DBL, 2'd2, 8'h02, w);
        rd(2'd2, 8'h04, w);
        check("ovf2_sticky", 32'(overflow[2]), 32'd1);
        cmd(OP_CLR, 2'd2, 8'hAA, w);
        check("ovf2_cleared", 32'(overflow[2]), 32'd0);
        rd(2'd2, 8'h00, w);
        wait_drain();

        // Fill the FIFO with out_ready low, hold a fifth READ, then drain.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd(2'd0, 8'd3, w);
        end
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("hold_out_ch", 32'(out_ch), 32'd0);
        check("hold_out_data", 32'(out_data), 32'd3);
        fork
            rd(2'd1, E_ADD_OVF, w5);
        join_none
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("fifth_held_count", 32'(count), 32'd4);
        check("fifth_held_valid", 32'(in_valid), 32'd1);
        out_ready = 1'b1;
        wait_drain();
        check("fifth_wait", 32'(w5), 32'd4);

        // Reset with two entries queued and acc[0]=7, no clock edge.
        out_ready = 1'b0;
        cmd(OP_ADD, 2'd0, 8'd4, w);
        cmd(OP_RD, 2'd0, 8'd0, w);
        cmd(OP_RD, 2'd0, 8'd0, w);
        check("pre_rst_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        check("async_rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("pop_empty_ignored", 32'(count), 32'd0);
        rd(2'd0, 8'd0, w);
        wait_drain();

        // Invalid channel: accepted, err pulse, no state change.
        cmd(OP_ADD, 2'd0, 8'd9, w);
        cmd(OP_ADD, 2'd3, 8'd5, w);
        check("err_pulse", 32'(err), 32'd1);
        check("err_no_push", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        check("err_one_cycle", 32'(err), 32'd0);
        rd(2'd0, 8'd9, w);
        rd(2'd1, 8'd0, w);
        rd(2'd2, 8'd0, w);
        check("err_no_overflow", 32'(overflow), 32'd0);
        wait_drain();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tfcall_accum.md
TFCALL_ACCUM -- requirements
Module: tfcall_accum

Interface
REQ-001 SHALL have parameter WIDTH, default 8: accumulator and data width in bits; minimum 2.
REQ-002 SHALL have parameter CHANNELS, default 4: number of independent accumulators; minimum 1.
REQ-003 SHALL have parameter DEPTH, default 4: output FIFO entries; power of two, minimum 2.
REQ-004 SHALL define CHW = max(1, clog2(CHANNELS)) and CW = clog2(DEPTH)+1.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 in_valid  input  1  command valid.
REQ-008 in_ready  output  1  command accepted when in_valid && in_ready.
REQ-009 in_op  input  2  command: 0 ADD, 1 DBL, 2 CLR, 3 READ.
REQ-010 in_ch  input  CHW  target channel.
REQ-011 in_data  input  WIDTH  operand; ignored for CLR and READ.
REQ-012 out_valid  output  1  FIFO head valid.
REQ-013 out_ready  input  1  consumer pops head when out_valid && out_ready.
REQ-014 out_ch  output  CHW  channel of the head entry.
REQ-015 out_data  output  WIDTH  accumulator snapshot of the head entry.
REQ-016 overflow  output  CHANNELS  sticky per-channel overflow flags.
REQ-017 err  output  1  one-cycle pulse on an accepted command with in_ch >= CHANNELS.
REQ-018 count  output  CW  current FIFO occupancy.

Function
REQ-019 in_ready SHALL equal !(count == DEPTH), for every opcode; it SHALL have no combinational path from out_ready.
REQ-020 ADD SHALL set acc[ch] to acc[ch]+in_data modulo 2^WIDTH; carry-out SHALL set overflow[ch].
REQ-021 DBL SHALL set acc[ch] to in_data<<1 truncated to WIDTH; in_data MSB=1 SHALL set overflow[ch].
REQ-022 CLR SHALL set acc[ch] to 0 and clear overflow[ch].
REQ-023 READ SHALL push {ch, acc[ch]} into the FIFO and leave acc[ch] unchanged.
REQ-024 A READ following a write to the same channel in the next cycle SHALL return the updated value.
REQ-025 Commands with in_ch >= CHANNELS SHALL be accepted, SHALL change no state, and SHALL pulse err the next cycle.
REQ-026 out_valid SHALL equal count != 0; there SHALL be no fall-through: a push into an empty FIFO SHALL raise out_valid one cycle after acceptance.
REQ-027 Simultaneous push and pop SHALL leave count unchanged; data SHALL leave in push order.
REQ-028 Read and write pointers SHALL wrap modulo DEPTH.
REQ-029 Pop with out_valid=0 SHALL be ignored.
REQ-030 out_ch and out_data SHALL hold the head entry stable while out_valid && !out_ready.

Reset
REQ-031 While rst=1, all acc SHALL be 0, overflow 0, count 0, out_valid 0, out_ch 0, out_data 0 and err 0, independent of clk.
REQ-032 Reset mid-operation SHALL discard every FIFO entry and any command in flight.
REQ-033 The first command SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-034 With TFCALL_ACCUM_SAT_EN defined, an ADD or DBL that overflows SHALL clamp acc[ch] to all-ones, and SHALL still set overflow[ch].
REQ-035 Without TFCALL_ACCUM_SAT_EN, ADD and DBL SHALL wrap as in REQ-020 and REQ-021.

Verification (WIDTH=8, CHANNELS=4, DEPTH=4 unless stated)
REQ-036 ADD ch0 1, ADD ch0 2, READ ch0 -> out_ch=0, out_data=3, overflow[0]=0, one cycle after the READ.
REQ-037 ADD ch1 200, ADD ch1 100, READ ch1 -> out_data=44 and overflow[1]=1; with SAT_EN, out_data=255.
REQ-038 DBL ch2 0x90, READ, then DBL ch2 0x02, READ -> outputs 0x20 then 0x04 and overflow[2]=1; with SAT_EN, outputs 0xFF then 0x04; a later CLR ch2 -> overflow[2]=0.
REQ-039 Four READs with out_ready=0 -> count=4 and in_ready=0; a fifth READ is held; out_ready=1 -> the four entries drain in order and the fifth is accepted after the first pop.
REQ-040 Assert rst with two entries queued and acc[0]=7 -> out_valid=0, count=0 and acc[0]=0 with no clock edge; a READ ch0 after release -> out_data=0.
REQ-041 Build with CHANNELS=3, ADD ch3 5 -> err=1 for one cycle and no accumulator or overflow change.
